mig_burst_bridge: RTL and testbench



---
 rtl/mig_bridge_pkg.sv | 17 +
 rtl/beat_shifter.sv | 40 ++++
 rtl/mig_burst_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_mig_burst_bridge.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_bridge_pkg.sv
// Shared definitions for the MIG burst bridge: FSM state encoding and MIG
// app_cmd opcodes.
package mig_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WFILL,
      ST_WISSUE,
      ST_RISSUE,
      ST_RWAIT,
      ST_RDRAIN
   } state_t;

   localparam logic [2:0] APP_CMD_WRITE = 3'b000;
   localparam logic [2:0] APP_CMD_READ  = 3'b001;

endpackage

// File: rtl/beat_shifter.sv
// NW-word shift register, most-significant word first, with parallel load
// and a count of words shifted since the last load/clear.
module beat_shifter #(
   parameter int WORD_W = 32,
   parameter int NW     = 4,
   parameter int CW     = $clog2(NW + 1)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   load,
   input  logic [NW*WORD_W-1:0]   load_data,
   input  logic                   shift,
   input  logic [WORD_W-1:0]      shift_in,
   output logic [NW*WORD_W-1:0]   data,
   output logic [WORD_W-1:0]      msw,
   output logic [CW-1:0]          count
);

   localparam int DW = NW * WORD_W;

   // New words enter at the bottom so the first word ends up in the MSW slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         count <= '0;
      end else if (load) begin
         data  <= load_data;
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (shift) begin
         data  <= (data << WORD_W) | DW'(shift_in);
         count <= count + CW'(1);
      end
   end

   assign msw = data[DW-1 -: WORD_W];

endmodule

// File: rtl/mig_burst_bridge.sv
// Word-serial command port to MIG 7-series app interface bridge: bursts of
// 1..2^LEN_W beats, word packing/unpacking, per-beat timeout.
module mig_burst_bridge
   import mig_bridge_pkg::*;
#(
   parameter int APP_ADDR_W  = 29,
   parameter int APP_DATA_W  = 128,
   parameter int WORD_W      = 32,
   parameter int LEN_W       = 4,
   parameter int ADDR_STRIDE = 8,
   parameter int TIMEOUT     = 1023
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    calib_done,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [APP_ADDR_W-1:0]   cmd_addr,
   input  logic [LEN_W-1:0]        cmd_len,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [WORD_W-1:0]       wr_word,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [WORD_W-1:0]       rd_word,
   output logic                    done,
   output logic                    err,
   output logic [APP_ADDR_W-1:0]   app_addr,
   output logic [2:0]              app_cmd,
   output logic                    app_en,
   input  logic                    app_rdy,
   output logic [APP_DATA_W-1:0]   app_wdf_data,
   output logic                    app_wdf_wren,
   output logic                    app_wdf_end,
   input  logic                    app_wdf_rdy,
   input  logic [APP_DATA_W-1:0]   app_rd_data,
   input  logic                    app_rd_data_valid,
   output logic [APP_DATA_W/8-1:0] app_wdf_mask
);

   localparam int NW = APP_DATA_W / WORD_W;
   localparam int CW = $clog2(NW + 1);
   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   state_t                state, next_state;
   logic [LEN_W-1:0]      len_q, beat_q;
   logic [TW-1:0]         tmo_q;
   logic [CW-1:0]         wr_count, rd_count;
   logic [WORD_W-1:0]     wr_msw_unused;
   logic [APP_DATA_W-1:0] rd_data_unused;
   logic accept, wr_shift, rd_load, rd_shift, beat_end, tmo_hit;
   logic last_beat, wr_hs_done, tmo_max, timed;

   assign last_beat    = (beat_q == len_q);
   assign wr_hs_done   = (!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy);
   assign tmo_max      = (tmo_q == TW'(TIMEOUT));
   assign timed        = (state == ST_WISSUE) || (state == ST_RISSUE) || (state == ST_RWAIT);
   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_mask = '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // A completing handshake wins over a timeout landing in the same cycle.
   always_comb begin
      next_state = state;
      cmd_ready  = 1'b0;
      wr_ready   = 1'b0;
      rd_valid   = 1'b0;
      accept     = 1'b0;
      wr_shift   = 1'b0;
      rd_load    = 1'b0;
      rd_shift   = 1'b0;
      beat_end   = 1'b0;
      tmo_hit    = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = calib_done;
            if (cmd_valid && calib_done) begin
               accept     = 1'b1;
               next_state = cmd_write ? ST_WFILL : ST_RISSUE;
            end
         end
         ST_WFILL: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               wr_shift = 1'b1;
               if (wr_count == CW'(NW - 1)) next_state = ST_WISSUE;
            end
         end
         ST_WISSUE: begin
            if (wr_hs_done) begin
               beat_end   = 1'b1;
               next_state = last_beat ? ST_IDLE : ST_WFILL;
            end else if (tmo_max) begin
               tmo_hit    = 1'b1;
               next_state = ST_IDLE;
            end
         end
         ST_RISSUE: begin
            if (app_rdy) begin
               next_state = ST_RWAIT;
            end else if (tmo_max) begin
               tmo_hit    = 1'b1;
               next_state = ST_IDLE;
            end
         end
         ST_RWAIT: begin
            if (app_rd_data_valid) begin
               rd_load    = 1'b1;
               next_state = ST_RDRAIN;
            end else if (tmo_max) begin
               tmo_hit    = 1'b1;
               next_state = ST_IDLE;
            end
         end
         ST_RDRAIN: begin
            rd_valid = 1'b1;
            if (rd_ready) begin
               rd_shift = 1'b1;
               if (rd_count == CW'(NW - 1)) begin
                  beat_end   = 1'b1;
                  next_state = last_beat ? ST_IDLE : ST_RISSUE;
               end
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Each strobe drops on its own handshake; later assignments take priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         app_addr     <= '0;
         app_cmd      <= APP_CMD_WRITE;
         app_en       <= 1'b0;
         app_wdf_wren <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         len_q        <= '0;
         beat_q       <= '0;
         tmo_q        <= '0;
      end else begin
         done  <= beat_end && last_beat;
         err   <= tmo_hit;
         tmo_q <= (timed && next_state == state) ? tmo_q + TW'(1) : '0;
         if (app_en && app_rdy)           app_en       <= 1'b0;
         if (app_wdf_wren && app_wdf_rdy) app_wdf_wren <= 1'b0;
         if (accept) begin
            app_addr <= cmd_addr;
            len_q    <= cmd_len;
            beat_q   <= '0;
            app_cmd  <= cmd_write ? APP_CMD_WRITE : APP_CMD_READ;
            app_en   <= !cmd_write;
         end
         if (state == ST_WFILL && next_state == ST_WISSUE) begin
            app_en       <= 1'b1;
            app_wdf_wren <= 1'b1;
         end
         if (beat_end && !last_beat) begin
            app_addr <= app_addr + APP_ADDR_W'(ADDR_STRIDE);
            beat_q   <= beat_q + LEN_W'(1);
            if (state == ST_RDRAIN) app_en <= 1'b1;
         end
         if (tmo_hit) begin
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
         end
      end
   end

   beat_shifter #(.WORD_W(WORD_W), .NW(NW), .CW(CW)) u_wr_pack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (accept || beat_end),
      .load      (1'b0),
      .load_data ('0),
      .shift     (wr_shift),
      .shift_in  (wr_word),
      .data      (app_wdf_data),
      .msw       (wr_msw_unused),
      .count     (wr_count)
   );

   beat_shifter #(.WORD_W(WORD_W), .NW(NW), .CW(CW)) u_rd_unpack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (accept),
      .load      (rd_load),
      .load_data (app_rd_data),
      .shift     (rd_shift),
      .shift_in  ('0),
      .data      (rd_data_unused),
      .msw       (rd_word),
      .count     (rd_count)
   );

endmodule

// File: tb/tb_mig_burst_bridge.sv
// Self-checking bench for mig_burst_bridge: a MIG/host behavioural model with
// expectation queues, directed corner cases and a randomized command loop.
module tb_mig_burst_bridge;
   import mig_bridge_pkg::*;

   localparam int AW  = 29;
   localparam int DW  = 128;
   localparam int WW  = 32;
   localparam int LW  = 4;
   localparam int TMO = 31;

   typedef struct packed {
      logic [2:0]    cmd;
      logic [AW-1:0] addr;
   } cmd_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            calib_done;
   logic            cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0]   cmd_addr;
   logic [LW-1:0]   cmd_len;
   logic            wr_valid, wr_ready;
   logic [WW-1:0]   wr_word;
   logic            rd_valid, rd_ready;
   logic [WW-1:0]   rd_word;
   logic            done, err;
   logic [AW-1:0]   app_addr;
   logic [2:0]      app_cmd;
   logic            app_en, app_rdy;
   logic [DW-1:0]   app_wdf_data;
   logic            app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [DW-1:0]   app_rd_data;
   logic            app_rd_data_valid;
   logic [DW/8-1:0] app_wdf_mask;

   int passes = 0;
   int checks = 0;
   int done_count = 0;
   int err_count = 0;
   int en_stall = 0, wdf_stall = 0, en_only = 0;

   cmd_t          exp_cmd[$];
   logic [DW-1:0] exp_wdata[$];
   logic [WW-1:0] exp_rd[$];
   logic [WW-1:0] host_words[$];
   logic [WW-1:0] given_words[$];
   logic [AW-1:0] obs_addr[$];
   logic [WW-1:0] obs_rd[$];
   logic [DW-1:0] obs_wdata;

   bit            drop_reads = 0, force_late = 0, rand_rdy = 1;
   int            bp_cmd = 0, bp_wdf = 0;

   mig_burst_bridge #(
      .APP_ADDR_W(AW), .APP_DATA_W(DW), .WORD_W(WW), .LEN_W(LW),
      .ADDR_STRIDE(8), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_word(wr_word),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_word(rd_word),
      .done(done), .err(err),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .app_wdf_mask(app_wdf_mask)
   );

   always #5 clk = ~clk;

   // Contents the MIG model returns for a given beat address.
   function automatic logic [DW-1:0] mem_beat(input logic [AW-1:0] a);
      logic [31:0] x;
      x = {3'b000, a};
      return {x * 32'd3 + 32'd1, ~x, x ^ 32'h5A5A_5A5A, {x[15:0], 16'hBEEF}};
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // MIG model: ready generation, backpressure windows, one outstanding read.
   initial begin : mig_model
      bit            s_rdhs, s_en, s_wren, pend;
      logic [AW-1:0] s_addr, paddr;
      int            dly;
      pend = 0; dly = 0; paddr = '0;
      app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data = '0;
      forever begin
         @(negedge clk);
         s_rdhs = rst_n && app_en && app_rdy && (app_cmd == 3'b001);
         s_en   = app_en;
         s_wren = app_wdf_wren;
         s_addr = app_addr;
         @(posedge clk); #1;
         app_rd_data_valid = 0;
         if (!rst_n) pend = 0;
         else if (force_late) begin
            app_rd_data_valid = 1; app_rd_data = mem_beat('0); force_late = 0;
         end else if (pend) begin
            if (dly == 0) begin
               app_rd_data_valid = 1; app_rd_data = mem_beat(paddr); pend = 0;
            end else dly--;
         end else if (s_rdhs && !drop_reads) begin
            pend = 1; dly = $urandom_range(0, 4); paddr = s_addr;
         end
         if (s_en && bp_cmd > 0) bp_cmd--;
         if (s_wren && bp_wdf > 0) bp_wdf--;
         app_rdy     = (bp_cmd > 0) ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
         app_wdf_rdy = (bp_wdf > 0) ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   // Compare process: every handshake is checked against the expectation queues.
   always @(negedge clk) begin : monitor
      cmd_t e;
      if (rst_n) begin
         if (app_en && app_rdy) begin
            obs_addr.push_back(app_addr);
            if (exp_cmd.size() == 0) checkOutput("unexpected_app_cmd", 1, 0);
            else begin
               e = exp_cmd.pop_front();
               checkOutput("app_cmd", app_cmd, e.cmd);
               checkOutput("app_addr", app_addr, e.addr);
            end
         end
         if (app_wdf_wren && app_wdf_rdy) begin
            obs_wdata = app_wdf_data;
            checkOutput("app_wdf_end", app_wdf_end, 1);
            checkOutput("app_wdf_mask", app_wdf_mask, 0);
            if (exp_wdata.size() == 0) checkOutput("unexpected_wdf_beat", 1, 0);
            else checkOutput("app_wdf_data", app_wdf_data, exp_wdata.pop_front());
         end
         if (rd_valid && rd_ready) begin
            obs_rd.push_back(rd_word);
            if (exp_rd.size() == 0) checkOutput("unexpected_rd_word", 1, 0);
            else checkOutput("rd_word", rd_word, exp_rd.pop_front());
         end
         if (done) done_count++;
         if (err)  err_count++;
         if (app_en && !app_rdy) en_stall++;
         if (app_wdf_wren && !app_wdf_rdy) wdf_stall++;
         if (app_en && !app_wdf_wren && app_cmd == 3'b000) en_only++;
      end
   end

   task automatic sendCmd(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
      int g = 0;
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
      @(negedge clk);
      while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
      if (!cmd_ready) checkOutput("cmd_accept_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
   endtask

   task automatic feedWords();
      int idx = 0, g = 0;
      while (idx < host_words.size() && g < 2000) begin
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_word  = host_words[idx];
         @(negedge clk);
         if (wr_valid && wr_ready) idx++;
         @(posedge clk); #1;
         g++;
      end
      wr_valid = 0;
      if (idx != host_words.size()) checkOutput("wr_feed_timeout", idx, host_words.size());
   endtask

   task automatic drainWords(input int n);
      int cnt = 0, g = 0;
      while (cnt < n && g < 3000) begin
         rd_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (rd_valid && rd_ready) cnt++;
         @(posedge clk); #1;
         g++;
      end
      rd_ready = 0;
      if (cnt != n) checkOutput("rd_drain_timeout", cnt, n);
   endtask

   task automatic waitDone();
      int g = 0;
      @(negedge clk);
      while (!done && !err && g < 400) begin @(negedge clk); g++; end
      if (!done && !err) checkOutput("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   // One full command: builds expectations from address/packing rules, drives it.
   task automatic applyStimulus(input bit wr, input logic [AW-1:0] a, input int len, input bit use_given);
      logic [AW-1:0] ab;
      logic [DW-1:0] beat;
      logic [WW-1:0] w;
      cmd_t          c;
      int            d0, e0;
      host_words.delete();
      for (int b = 0; b <= len; b++) begin
         ab = a + AW'(b * 8);
         c.cmd = wr ? 3'b000 : 3'b001;
         c.addr = ab;
         exp_cmd.push_back(c);
         if (wr) begin
            beat = '0;
            for (int k = 0; k < 4; k++) begin
               w = use_given ? given_words[b*4+k] : $urandom;
               host_words.push_back(w);
               beat[DW-1-32*k -: 32] = w;
            end
            exp_wdata.push_back(beat);
         end else begin
            beat = mem_beat(ab);
            for (int k = 0; k < 4; k++) exp_rd.push_back(beat[DW-1-32*k -: 32]);
         end
      end
      d0 = done_count; e0 = err_count;
      sendCmd(wr, a, LW'(len));
      if (wr) feedWords();
      else    drainWords((len + 1) * 4);
      waitDone();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("done_pulses", done_count - d0, 1);
      checkOutput("err_pulses", err_count - e0, 0);
      checkOutput("cmd_queue_empty", exp_cmd.size(), 0);
      checkOutput("wdata_queue_empty", exp_wdata.size(), 0);
      checkOutput("rd_queue_empty", exp_rd.size(), 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int d0, e0, k, g;
      cmd_t c;
      rst_n = 0; calib_done = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 0; wr_word = '0; rd_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_app_en", app_en, 0);
      checkOutput("rst_app_wdf_wren", app_wdf_wren, 0);
      checkOutput("rst_app_wdf_end", app_wdf_end, 0);
      checkOutput("rst_rd_valid", rd_valid, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_app_cmd", app_cmd, 0);
      checkOutput("rst_app_addr", app_addr, 0);
      checkOutput("rst_app_wdf_data", app_wdf_data, 0);
      checkOutput("rst_rd_word", rd_word, 0);
      checkOutput("rst_state", dut.state, ST_IDLE);
      rst_n = 1;

      // Calibration gating: command held but never accepted.
      cmd_valid = 1; cmd_write = 1; cmd_addr = 29'h100;
      repeat (8) begin
         @(negedge clk);
         checkOutput("calib_cmd_ready", cmd_ready, 0);
         checkOutput("calib_app_en", app_en, 0);
      end
      @(posedge clk); #1;
      cmd_valid = 0; calib_done = 1;
      @(posedge clk); #1;

      // Single write with known words.
      given_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      obs_addr.delete();
      applyStimulus(1, 29'h100, 0, 1);
      checkOutput("single_write_data", obs_wdata, 128'h11111111_22222222_33333333_44444444);
      checkOutput("single_write_addr", obs_addr.size() > 0 ? obs_addr[0] : '1, 29'h100);

      // Burst read of three beats.
      obs_addr.delete(); obs_rd.delete();
      applyStimulus(0, 29'h1F8, 2, 0);
      checkOutput("burst_addr_count", obs_addr.size(), 3);
      if (obs_addr.size() == 3) begin
         checkOutput("burst_addr0", obs_addr[0], 29'h1F8);
         checkOutput("burst_addr1", obs_addr[1], 29'h200);
         checkOutput("burst_addr2", obs_addr[2], 29'h208);
      end
      checkOutput("burst_word_count", obs_rd.size(), 12);
      if (obs_rd.size() >= 2) begin
         checkOutput("burst_first_word", obs_rd[0], 32'h000005E9);
         checkOutput("burst_second_word", obs_rd[1], 32'hFFFFFE07);
      end

      // Backpressure: command ready stalled 20 cycles, data ready 5.
      rand_rdy = 0; bp_cmd = 20; bp_wdf = 5;
      en_stall = 0; wdf_stall = 0; en_only = 0;
      applyStimulus(1, 29'h300, 0, 0);
      checkOutput("bp_app_en_stall", en_stall, 20);
      checkOutput("bp_wdf_wren_stall", wdf_stall, 5);
      checkOutput("bp_independent_drop", en_only, 15);
      rand_rdy = 1;

      // Timeout: read accepted but data never returns.
      drop_reads = 1; e0 = err_count; d0 = done_count;
      c.cmd = 3'b001; c.addr = 29'h40;
      exp_cmd.push_back(c);
      sendCmd(0, 29'h40, 0);
      g = 0;
      @(negedge clk);
      while (!(app_en && app_rdy) && g < 200) begin @(negedge clk); g++; end
      k = 0;
      do begin @(negedge clk); k++; end while (!err && k < 200);
      checkOutput("timeout_latency", k, TMO + 2);
      checkOutput("timeout_cmd_ready", cmd_ready, 1);
      checkOutput("timeout_no_done", done, 0);
      force_late = 1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("late_valid_ignored", rd_valid, 0);
      end
      checkOutput("late_valid_state", dut.state, ST_IDLE);
      drop_reads = 0;
      @(posedge clk); #1;
      checkOutput("timeout_err_pulses", err_count - e0, 1);
      checkOutput("timeout_done_pulses", done_count - d0, 0);

      // Address wrap at the top of the address space.
      obs_addr.delete();
      applyStimulus(1, 29'h1FFFFFF8, 1, 0);
      checkOutput("wrap_addr_count", obs_addr.size(), 2);
      if (obs_addr.size() == 2) begin
         checkOutput("wrap_addr0", obs_addr[0], 29'h1FFFFFF8);
         checkOutput("wrap_addr1", obs_addr[1], 29'h0);
      end

      // Asynchronous reset while a write beat is being issued.
      bp_cmd = 1000; bp_wdf = 1000;
      host_words = '{$urandom, $urandom, $urandom, $urandom};
      sendCmd(1, 29'h80, 0);
      feedWords();
      g = 0;
      @(negedge clk);
      while (!app_en && g < 50) begin @(negedge clk); g++; end
      repeat (2) @(negedge clk);
      #2 rst_n = 0;
      #1;
      checkOutput("async_rst_app_en", app_en, 0);
      checkOutput("async_rst_wdf_wren", app_wdf_wren, 0);
      checkOutput("async_rst_wdf_end", app_wdf_end, 0);
      @(negedge clk);
      rst_n = 1; bp_cmd = 0; bp_wdf = 0;
      @(negedge clk);
      checkOutput("post_rst_state", dut.state, ST_IDLE);
      checkOutput("post_rst_cmd_ready", cmd_ready, 1);
      checkOutput("post_rst_app_en", app_en, 0);
      @(posedge clk); #1;

      // Randomized commands.
      for (int i = 0; i < 30; i++) begin
         applyStimulus($urandom_range(0, 1), AW'($urandom), $urandom_range(0, 7), 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
